// File: rtl/axis_rr_pkt_arbiter.sv
// Round-robin AXI-Stream packet arbiter.
// NUM requesters share one downstream port. A grant is issued from IDLE one
// cycle after a request is seen and is held for a whole packet (until the
// tlast handshake). The search then resumes at the requester after the one
// just served. Beats are counted per packet, and err_overlong flags the beat
// that pushes a packet past MAX_BEATS. The packet itself is still passed
// through unchanged.
module axis_rr_pkt_arbiter #(
    parameter int NUM       = 4,
    parameter int DSIZE     = 8,
    parameter int USIZE     = 1,
    parameter int MAX_BEATS = 256
) (
    input  logic                     clock,
    input  logic                     rst_n,
    input  logic [NUM-1:0]           s_tvalid,
    output logic [NUM-1:0]           s_tready,
    input  logic [NUM*DSIZE-1:0]     s_tdata,
    input  logic [NUM*USIZE-1:0]     s_tuser,
    input  logic [NUM-1:0]           s_tlast,
    output logic                     m_tvalid,
    input  logic                     m_tready,
    output logic [DSIZE-1:0]         m_tdata,
    output logic [USIZE-1:0]         m_tuser,
    output logic                     m_tlast,
    output logic [$clog2(NUM)-1:0]   m_tid,
    output logic                     err_overlong
);

    localparam int IW = $clog2(NUM);
    // Wide enough to hold the saturation value MAX_BEATS+1.
    localparam int CW = $clog2(MAX_BEATS + 2);

    typedef enum logic {
        IDLE = 1'b0,
        LOCK = 1'b1
    } state_t;

    state_t          state;
    logic [IW-1:0]   sel;
    logic [IW-1:0]   rr_ptr;
    logic [CW-1:0]   beat_cnt;

    logic            pick_found;
    logic [IW-1:0]   pick_idx;
    int              cand;
    logic            hs;

    // Beat counter increment that sticks at MAX_BEATS+1 so very long packets
    // cannot wrap the counter and raise the error a second time.
    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
        if (v == CW'(MAX_BEATS + 1)) begin
            return v;
        end
        return v + CW'(1);
    endfunction

    // Next requester index, wrapping at NUM (which need not be a power of two).
    function automatic logic [IW-1:0] wrap_inc(input logic [IW-1:0] v);
        if (int'(v) == NUM - 1) begin
            return '0;
        end
        return v + IW'(1);
    endfunction

    // Round-robin search starting at rr_ptr. The loop runs from the farthest
    // offset down to offset 0, so the candidate nearest rr_ptr is written last
    // and wins.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        cand       = 0;
        for (int i = NUM - 1; i >= 0; i--) begin
            cand = (int'(rr_ptr) + i) % NUM;
            if (s_tvalid[cand[IW-1:0]]) begin
                pick_found = 1'b1;
                pick_idx   = cand[IW-1:0];
            end
        end
    end

    // A downstream transfer can only happen while a grant is held.
    assign hs = (state == LOCK) && s_tvalid[sel] && m_tready;

    // The pulse lines up with the handshake of beat MAX_BEATS+1 itself.
    assign err_overlong = hs && (beat_cnt == CW'(MAX_BEATS));

    // Steer the granted requester to the shared port. In IDLE everything is
    // quiet. In LOCK the path is purely combinational, so a stalled requester's
    // held payload reaches the output unchanged.
    always_comb begin
        m_tvalid = 1'b0;
        m_tdata  = '0;
        m_tuser  = '0;
        m_tlast  = 1'b0;
        s_tready = '0;
        m_tid    = sel;
        if (state == LOCK) begin
            m_tvalid      = s_tvalid[sel];
            m_tdata       = s_tdata[sel*DSIZE +: DSIZE];
            m_tuser       = s_tuser[sel*USIZE +: USIZE];
            m_tlast       = s_tlast[sel];
            s_tready[sel] = m_tready;
        end
    end

    // Grant FSM: latch a winner in IDLE and hold it through the tlast
    // handshake. Then advance the round-robin pointer past the served
    // requester, which leaves one idle bubble before the next grant.
    always_ff @(posedge clock) begin
        if (!rst_n) begin
            state    <= IDLE;
            sel      <= '0;
            rr_ptr   <= '0;
            beat_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_found) begin
                        sel      <= pick_idx;
                        beat_cnt <= '0;
                        state    <= LOCK;
                    end
                end
                LOCK: begin
                    if (hs) begin
                        beat_cnt <= sat_inc(beat_cnt);
                        if (s_tlast[sel]) begin
                            rr_ptr <= wrap_inc(sel);
                            state  <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/axis_rr_pkt_arbiter.md
AXIS_RR_PKT_ARBITER -- requirements
Module: axis_rr_pkt_arbiter

Interface
REQ-001 SHALL have parameter NUM, default 4, meaning the number of AXI-Stream requesters (2..8).
REQ-002 SHALL have parameter DSIZE, default 8, meaning the tdata width per requester.
REQ-003 SHALL have parameter USIZE, default 1, meaning the tuser width per requester.
REQ-004 SHALL have parameter MAX_BEATS, default 256, meaning the beat count above which a packet is flagged overlong.
REQ-005 SHALL have port clock, input, 1 bit: the single clock; all logic on its rising edge.
REQ-006 SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-007 SHALL have port s_tvalid, input, NUM bits: per-requester valid.
REQ-008 SHALL have port s_tready, output, NUM bits: per-requester ready.
REQ-009 SHALL have port s_tdata, input, NUM*DSIZE bits: requester i occupies bits [i*DSIZE +: DSIZE].
REQ-010 SHALL have port s_tuser, input, NUM*USIZE bits: packed the same way as s_tdata.
REQ-011 SHALL have port s_tlast, input, NUM bits: per-requester end-of-packet.
REQ-012 SHALL have port m_tvalid, output, 1 bit; m_tready, input, 1 bit: shared downstream handshake.
REQ-013 SHALL have ports m_tdata (DSIZE), m_tuser (USIZE), m_tlast (1), all outputs: shared downstream payload.
REQ-014 SHALL have port m_tid, output, $clog2(NUM) bits: index of the granted requester.
REQ-015 SHALL have port err_overlong, output, 1 bit: one-cycle pulse when a packet exceeds MAX_BEATS.

Function
REQ-016 SHALL implement a two-state FSM, IDLE and LOCK.
REQ-017 In IDLE, SHALL drive m_tvalid=0 and s_tready=0.
REQ-018 In IDLE with any s_tvalid bit set, SHALL select the first set bit searching upward from rr_ptr and wrapping (rr_ptr, rr_ptr+1, ..., NUM-1, 0, ...).
REQ-019 On that selection, SHALL register the index into sel and enter LOCK on the next edge; grant latency is exactly 1 cycle from valid seen in IDLE.
REQ-020 In LOCK, SHALL drive combinationally: m_tvalid=s_tvalid[sel]; m_tdata/m_tuser/m_tlast = slice sel; s_tready[sel]=m_tready; all other s_tready bits 0; m_tid=sel.
REQ-021 SHALL hold the grant until a handshake (m_tvalid and m_tready) with m_tlast=1; the grant SHALL NOT change mid-packet, even if s_tvalid[sel] drops.
REQ-022 On the tlast handshake, SHALL return to IDLE and set rr_ptr=(sel+1) mod NUM, giving one idle bubble cycle between packets.
REQ-023 In LOCK, beat_cnt SHALL start at 0 on grant and increment on each handshake, saturating at MAX_BEATS+1.
REQ-024 SHALL pulse err_overlong for one cycle on the handshake that takes beat_cnt from MAX_BEATS to MAX_BEATS+1.
REQ-025 Overlong packets SHALL continue to pass until tlast; no truncation.
REQ-026 A single-beat packet (tlast on the first beat) SHALL be legal: LOCK for exactly one handshake, then IDLE.
REQ-027 Requesters not granted SHALL see s_tready=0 and keep their data; the arbiter SHALL NOT drop or duplicate beats.
REQ-028 With m_tready=0 in LOCK, SHALL hold all outputs stable as required by the AXI-Stream hold rule.

Reset
REQ-029 While rst_n=0 at a clock edge: state=IDLE, sel=0, rr_ptr=0, beat_cnt=0, err_overlong=0; hence m_tvalid=0, s_tready=0, m_tid=0, m_tdata/m_tuser/m_tlast=0.
REQ-030 Reset asserted mid-packet SHALL abandon the grant immediately, with no further handshakes after the reset edge; the first arbitration after reset SHALL start from requester 0.

Verification
REQ-031 Post-reset, requesters 0 and 2 both valid with 3-beat packets, m_tready=1 -> sel=0 granted cycle 1, 3 beats, bubble, then sel=2; rr_ptr=3 afterwards.
REQ-032 All 4 requesters valid continuously, 1-beat packets -> m_tid sequence 0,1,2,3,0,1,... with one bubble between each.
REQ-033 Requester 1 granted, s_tvalid[1] drops for 2 cycles mid-packet while 3 is valid -> m_tvalid=0 for those cycles, s_tready[3]=0, grant stays 1 until its tlast.
REQ-034 MAX_BEATS=4, packet of 6 beats -> err_overlong pulses exactly on beat 5; all 6 beats delivered intact.
REQ-035 m_tready toggled randomly during a 5-beat packet -> payload stable while stalled; output sequence equals input sequence.
REQ-036 rst_n=0 during beat 2 of a packet -> next cycle m_tvalid=0, s_tready=0; after release, the lowest-index valid requester is granted.
